// File: rtl/muacm_tx_packer.sv
// muacm_tx_packer: byte FIFO plus packetiser feeding the muACM data-in stream.
// Defining MUACM_TX_FLUSH_EN adds the `flush` input that forces an early packet end.
module muacm_tx_packer #(
  parameter int DEPTH_LOG2 = 6,
  parameter int MAX_PKT    = 64,
  parameter int TIMEOUT    = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
`ifdef MUACM_TX_FLUSH_EN
  input  logic       flush,
`endif
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       state_o
);

  // Handshake on both streams: a beat transfers on the rising edge where valid & ready are
  // both high; once m_valid is high, m_valid/m_data/m_last stay stable until that edge.

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int RW    = $clog2(MAX_PKT) + 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_C     = CW'(MAX_PKT);
  localparam logic [RW-1:0] MAX_R     = RW'(MAX_PKT);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  wr_en, pop, flush_req;

  assign s_ready = (count_q != DEPTH_C);
  assign wr_en   = s_valid & s_ready;
  assign pop     = (state_q == SEND) & m_ready;
  assign m_valid = (state_q == SEND);
  assign m_last  = (state_q == SEND) && (rem_q == RW'(1));
  // Writes never land on the head slot while data is buffered, so the head stays stable.
  assign m_data  = mem_q[rd_ptr_q];
  assign state_o = state_q;

  always_comb begin
    flush_req = 1'b0;
`ifdef MUACM_TX_FLUSH_EN
    flush_req = flush;
`endif
    state_d  = state_q;
    rem_d    = rem_q;
    wr_ptr_d = wr_en ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    count_d  = count_q;
    timer_d  = timer_q;

    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (wr_en || count_q == '0) begin
      timer_d = '0;
    end else if (state_q == IDLE && timer_q != TIMEOUT_C) begin
      timer_d = timer_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        // The count>0 guard also masks a stale saturated timer left after a drained packet.
        if (count_q != '0 && (count_q >= MAX_C || timer_q == TIMEOUT_C || flush_req)) begin
          state_d = SEND;
          rem_d   = (count_q >= MAX_C) ? MAX_R : RW'(count_q);
        end
      end
      SEND: begin
        if (m_ready) begin
          rem_d = rem_q - RW'(1);
          if (rem_q == RW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rem_q    <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      timer_q  <= timer_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= s_data;
  end

endmodule

// File: tb/tb_muacm_tx_packer.sv
// Directed-plus-random bench for muacm_tx_packer; a negedge monitor keeps a byte queue
// model and derives packet lengths and m_last positions from the packetising rules.
`timescale 1ns/1ps
module tb_muacm_tx_packer;
  localparam int MAX_PKT = 64;
  localparam int TIMEOUT = 1023;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       m_ready;
  logic       state_o;
`ifdef MUACM_TX_FLUSH_EN
  logic       flush;
`endif

  muacm_tx_packer #(.DEPTH_LOG2(6), .MAX_PKT(MAX_PKT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
`ifdef MUACM_TX_FLUSH_EN
    .flush(flush),
`endif
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish, expected finish before 90000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard / reference model
  logic [7:0] exp_q[$];
  int         pkt_len_q[$];
  int         pkt_start_q[$];
  int         pkt_end_q[$];
  int         pkts_done = 0;
  int         beat_idx = 0;
  int         exp_len = 0;
  int         last_wr_cyc = 0;
  bit         in_pkt = 0, stall_prev = 0, wrote_prev = 0, valid_prev = 0;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      in_pkt = 0; stall_prev = 0; wrote_prev = 0; valid_prev = 0;
    end else begin
      if (m_valid) begin
        if (!in_pkt) begin
          // Bytes written on the start edge itself are not part of this packet.
          exp_len = exp_q.size() - (wrote_prev ? 1 : 0);
          if (exp_len > MAX_PKT) exp_len = MAX_PKT;
          check("idle_gap", valid_prev, 1'b0);
          beat_idx = 0; in_pkt = 1;
          pkt_start_q.push_back(cyc);
        end
        if (stall_prev) begin
          check("hold_data", m_data, prev_data);
          check("hold_last", m_last, prev_last);
        end
        check("model_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          check("m_data", m_data, exp_q[0]);
          check("m_last", m_last, beat_idx == exp_len - 1);
        end
        if (m_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          beat_idx++;
          stall_prev = 0;
          if (m_last) begin
            pkts_done++;
            pkt_len_q.push_back(beat_idx);
            pkt_end_q.push_back(cyc);
            in_pkt = 0;
          end
        end else begin
          stall_prev = 1; prev_data = m_data; prev_last = m_last;
        end
      end else begin
        if (stall_prev) check("hold_valid", m_valid, 1'b1);
        in_pkt = 0; stall_prev = 0;
      end
      valid_prev = m_valid;
      wrote_prev = s_valid && s_ready;
      if (wrote_prev) begin
        exp_q.push_back(s_data);
        last_wr_cyc = cyc;
      end
    end
  end

  // random downstream readiness
  bit rnd_ready = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_ready) m_ready = ($urandom_range(0, 99) < 30);
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int n;
    s_data = b; s_valid = 1'b1; n = 0;
    do begin
      @(negedge clk); n++;
    end while (!s_ready && n < 3000);
    if (!s_ready) check("s_ready_timeout", s_ready, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_pkts(input int n, input int budget);
    int k;
    k = 0;
    while (pkts_done < n && k < budget) begin
      @(negedge clk); k++;
    end
    check("pkt_wait", pkts_done >= n, 1'b1);
    @(posedge clk); #1;
  endtask

  int p0, s0, w63, ws;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
`ifdef MUACM_TX_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_s_ready", s_ready, 1'b1);
    @(posedge clk); #1;

    // three bytes, short packet after idle timeout
    m_ready = 1'b1;
    p0 = pkts_done; s0 = pkt_start_q.size();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    wait_pkts(p0 + 1, TIMEOUT + 100);
    if (pkts_done > p0) check("t1_len", pkt_len_q[p0], 3);
    if (pkt_start_q.size() > s0) check("t1_latency", pkt_start_q[s0] - last_wr_cyc, TIMEOUT + 2);

    // 100 bytes back-to-back: full packet then timeout remainder
    p0 = pkts_done; s0 = pkt_start_q.size(); w63 = 0;
    for (int i = 0; i < 100; i++) begin
      send_byte(8'(i));
      if (i == 63) w63 = last_wr_cyc;
    end
    wait_pkts(p0 + 2, TIMEOUT + 400);
    if (pkts_done > p0 + 1) begin
      check("t2_len0", pkt_len_q[p0], 64);
      check("t2_len1", pkt_len_q[p0 + 1], 36);
    end
    if (pkt_start_q.size() > s0 + 1) begin
      check("t2_full_latency", pkt_start_q[s0] - w63, 2);
      check("t2_short_latency", pkt_start_q[s0 + 1] - pkt_end_q[p0], TIMEOUT + 2);
    end

    // random data, downstream ready about 30% of cycles
    p0 = pkts_done;
    rnd_ready = 1;
    for (int i = 0; i < 100; i++) send_byte(8'($urandom));
    wait_pkts(p0 + 2, TIMEOUT + 1500);
    rnd_ready = 0; m_ready = 1'b1;
    if (pkts_done > p0 + 1) begin
      check("t3_len0", pkt_len_q[p0], 64);
      check("t3_len1", pkt_len_q[p0 + 1], 36);
    end

    // fill with downstream stalled, 65th byte held until one pop
    @(posedge clk); #1;
    m_ready = 1'b0;
    p0 = pkts_done;
    for (int i = 0; i < 64; i++) send_byte(8'(8'h80 + i));
    @(negedge clk);
    check("t4_full", s_ready, 1'b0);
    @(posedge clk); #1;
    s_data = 8'hC0; s_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("t4_full_hold", s_ready, 1'b0);
    check("t4_pkt_pending", m_valid, 1'b1);
    @(posedge clk); #1 m_ready = 1'b1;
    @(posedge clk); #1 m_ready = 1'b0;
    @(negedge clk);
    check("t4_ready_after_pop", s_ready, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0; m_ready = 1'b1;
    wait_pkts(p0 + 2, TIMEOUT + 300);
    if (pkts_done > p0 + 1) begin
      check("t4_len0", pkt_len_q[p0], 64);
      check("t4_len1", pkt_len_q[p0 + 1], 1);
    end

    // reset during beat 10 of a full packet
    p0 = pkts_done;
    for (int i = 0; i < 64; i++) send_byte(8'(8'h40 + i));
    ws = last_wr_cyc;
    while (cyc < ws + 11) @(negedge clk);
    check("t5_pre_rst_valid", m_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_valid", m_valid, 1'b0);
    check("t5_rst_last", m_last, 1'b0);
    check("t5_rst_ready", s_ready, 1'b1);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    check("t5_no_partial", pkts_done, p0);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    wait_pkts(p0 + 1, TIMEOUT + 100);
    if (pkts_done > p0) check("t5_len", pkt_len_q[p0], 3);

`ifdef MUACM_TX_FLUSH_EN
    // flush forces an early short packet; flush with nothing buffered does nothing
    p0 = pkts_done; s0 = pkt_start_q.size();
    for (int i = 0; i < 5; i++) send_byte(8'(8'hF0 + i));
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    wait_pkts(p0 + 1, 200);
    if (pkts_done > p0) check("t6_len", pkt_len_q[p0], 5);
    if (pkt_start_q.size() > s0) check("t6_latency", pkt_start_q[s0] - last_wr_cyc, 4);
    s0 = pkt_start_q.size();
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_empty_flush", pkt_start_q.size(), s0);
    check("t6_empty_valid", m_valid, 1'b0);
`endif

    repeat (4) @(negedge clk);
    check("end_model_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
